collection_scheduler: RTL and testbench
=======================================

COLLECTION_SCHEDULER -- requirements
Module: collection_scheduler

Interface
REQ-001 Parameter POSITION, default 243: command-bus unit position, matched against addr[15:8].
REQ-002 Parameter MAX_SLOTS, default 8: number of schedulable slots.
REQ-003 Parameter PERIOD_W, default 24: width of each slot's period counter.
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 addr  input  16  command-bus address; [15:8] unit position, [7:0] register.
REQ-007 cmd_data_in  input  32  command-bus write data.
REQ-008 cs  input  1  command-bus chip select.
REQ-009 wr  input  1  command-bus write strobe.
REQ-010 req_ready  input  1  collector accepts the current request.
REQ-011 req_valid  output  1  sample request pending toward the collector.
REQ-012 req_channel  output  8  channel position of the requested slot.
REQ-013 req_slot  output  3  slot index of the requested slot.
REQ-014 running  output  1  high while the scheduler is in the ARB or ISSUE state.
REQ-015 overrun  output  1  sticky flag: a slot's period expired while its previous request was still pending.
REQ-016 num_slots  output  4  number of configured slots.

Function
REQ-017 A bus write is a cycle with cs=1, wr=1 and addr[15:8]==POSITION; all other cycles are ignored.
REQ-018 A write to addr[7:0]=4 (ADD_SLOT) appends a slot at index num_slots: channel=data[7:0], period=data[31:8] truncated to PERIOD_W, with period 0 treated as 1; num_slots increments by 1.
REQ-019 ADD_SLOT is ignored when num_slots==MAX_SLOTS or the state is not IDLE.
REQ-020 A write to addr[7:0]=5 (COMMAND) captures data[15:0] as the command: 1=START, 2=STOP, 5=CLEAR; other values are ignored.
REQ-021 States: IDLE, ARB, ISSUE, DRAIN (one-hot).
REQ-022 IDLE + START with num_slots>0: each slot counter loads period-1, every configured slot's pending bit is set, the round-robin pointer rr is set to 0, and the next state is ARB.
REQ-023 IDLE + START with num_slots==0: no effect.
REQ-024 In ARB and ISSUE, each slot counter decrements every cycle; at 0 it reloads period-1 and sets that slot's pending bit.
REQ-025 Expiry while the slot's pending bit is already set (and not being granted the same cycle) sets overrun and drops the new request.
REQ-026 ARB: if any bit is pending, latch the first pending slot at or after rr, searching cyclically modulo num_slots, and go to ISSUE; otherwise stay in ARB.
REQ-027 ISSUE: req_valid=1 and req_channel/req_slot stay stable until req_ready=1.
REQ-028 On handshake (req_valid and req_ready): clear the granted slot's pending bit and set rr=(slot+1) mod num_slots.
REQ-029 If the granted slot expires in the same cycle as its handshake, its pending bit stays set and overrun is not set.
REQ-030 Minimum latency from a START write at cycle T to req_valid=1 is cycle T+2; from a handshake to the next req_valid it is 2 cycles.
REQ-031 STOP or CLEAR received in ARB: counters freeze, all pending bits clear, and the next state is IDLE.
REQ-032 STOP or CLEAR received in ISSUE: go to DRAIN and hold req_valid until the handshake; a request is never retracted.
REQ-033 DRAIN: completes the handshake, then clears all pending bits and goes to IDLE.
REQ-034 CLEAR reaching IDLE (directly or via ARB/DRAIN) also sets num_slots=0, sets all slot channels to 255, and clears overrun.
REQ-035 START received while not in IDLE is ignored.
REQ-036 A captured command is consumed (reset to 0) in the cycle it is acted upon or ignored.

Reset
REQ-037 rst forces state IDLE, num_slots=0, all channels=255, all pending bits=0, counters=0, rr=0, command=0.
REQ-038 rst forces outputs req_valid=0, req_channel=255, req_slot=0, running=0, overrun=0.
REQ-039 rst asserted mid-request drops req_valid the next cycle without a handshake.

Verification
REQ-040 Add slots {ch 3, period 4} and {ch 7, period 4}, START, req_ready=1 constantly -> requests alternate 3,7,3,7; no overrun.
REQ-041 One slot {ch 9, period 2}, req_ready held 0 for 10 cycles -> req_valid stays high with req_channel=9; overrun=1.
REQ-042 START with num_slots=0 -> running stays 0 and req_valid stays 0.
REQ-043 STOP while req_valid=1 and req_ready=0, then req_ready=1 after 5 cycles -> one handshake, then IDLE and req_valid=0.
REQ-044 9 ADD_SLOT writes with MAX_SLOTS=8 -> num_slots=8; ADD_SLOT while running -> num_slots unchanged.
REQ-045 CLEAR after an overrun -> overrun=0, num_slots=0, state IDLE.

Source files
------------

// File: rtl/collection_scheduler.sv
// Periodic sample-request scheduler: up to MAX_SLOTS (channel, period) slots whose
// expiries raise pending bits, granted round-robin to a ready/valid collector.
module collection_scheduler_slot #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                add_i,
  input  logic [7:0]          chan_i,
  input  logic [PERIOD_W-1:0] per_i,
  input  logic                start_i,
  input  logic                run_i,
  input  logic                wipe_i,
  output logic [7:0]          chan_o,
  output logic                expire_o
);
  localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);
  logic [7:0]          chan_q;
  logic [PERIOD_W-1:0] per_q, cnt_q;

  assign chan_o   = chan_q;
  assign expire_o = run_i && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      chan_q <= 8'hFF;
      per_q  <= '0;
      cnt_q  <= '0;
    end else begin
      if (wipe_i) begin
        chan_q <= 8'hFF;
        per_q  <= '0;
      end else if (add_i) begin
        chan_q <= chan_i;
        per_q  <= (per_i == '0) ? ONE : per_i;
      end
      if (start_i)    cnt_q <= per_q - ONE;
      else if (run_i) cnt_q <= expire_o ? per_q - ONE : cnt_q - ONE;
    end
  end
endmodule

module collection_scheduler #(
  parameter int POSITION  = 243,
  parameter int MAX_SLOTS = 8,
  parameter int PERIOD_W  = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [31:0] cmd_data_in,
  input  logic        cs,
  input  logic        wr,
  input  logic        req_ready,
  output logic        req_valid,
  output logic [7:0]  req_channel,
  output logic [2:0]  req_slot,
  output logic        running,
  output logic        overrun,
  output logic [3:0]  num_slots
);
  typedef enum logic [3:0] {IDLE = 4'b0001, ARB = 4'b0010, ISSUE = 4'b0100, DRAIN = 4'b1000} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             num_q, num_d;
  logic [MAX_SLOTS-1:0]   pend_q, pend_d, pend_run, cfg, gnt, exp_v, add_v;
  logic [2:0]             rr_q, rr_d, slot_q, slot_d, pick;
  logic [7:0]             ch_q, ch_d;
  logic                   ovr_q, ovr_d, clr_q, clr_d, ovr_hit, found;
  logic                   wr_hit, add_w, start_c, halt, clr_c, hs, run, start, wipe;
  logic [15:0]            cmd;
  logic [3:0]             idx;
  logic [MAX_SLOTS-1:0][7:0] chan_v;

  // Commands act in the cycle they are written, so nothing lingers to be consumed later.
  assign wr_hit  = cs && wr && (addr[15:8] == 8'(POSITION));
  assign add_w   = wr_hit && (addr[7:0] == 8'd4);
  assign cmd     = (wr_hit && (addr[7:0] == 8'd5)) ? cmd_data_in[15:0] : 16'd0;
  assign start_c = (cmd == 16'd1);
  assign clr_c   = (cmd == 16'd5);
  assign halt    = (cmd == 16'd2) || clr_c;
  assign hs      = ((state_q == ISSUE) || (state_q == DRAIN)) && req_ready;
  assign run     = ((state_q == ARB) && !halt) || (state_q == ISSUE);

  assign req_valid   = (state_q == ISSUE) || (state_q == DRAIN);
  assign running     = (state_q == ARB) || (state_q == ISSUE);
  assign req_channel = ch_q;
  assign req_slot    = slot_q;
  assign overrun     = ovr_q;
  assign num_slots   = num_q;

  for (genvar i = 0; i < MAX_SLOTS; i++) begin : g_slot
    collection_scheduler_slot #(.PERIOD_W(PERIOD_W)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .add_i   (add_v[i]),
      .chan_i  (cmd_data_in[7:0]),
      .per_i   (PERIOD_W'(cmd_data_in[31:8])),
      .start_i (start),
      .run_i   (run && cfg[i]),
      .wipe_i  (wipe),
      .chan_o  (chan_v[i]),
      .expire_o(exp_v[i])
    );
  end

  always_comb begin
    ovr_hit = 1'b0;
    pick    = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < MAX_SLOTS; i++) begin
      cfg[i]      = (4'(i) < num_q);
      gnt[i]      = hs && (slot_q == 3'(i));
      add_v[i]    = (state_q == IDLE) && add_w && (num_q < 4'(MAX_SLOTS)) && (num_q == 4'(i));
      pend_run[i] = (pend_q[i] && !gnt[i]) || exp_v[i];
      ovr_hit     = ovr_hit || (exp_v[i] && pend_q[i] && !gnt[i]);
    end
    // Cyclic search from rr, wrapping at num_slots rather than MAX_SLOTS.
    for (int k = 0; k < MAX_SLOTS; k++) begin
      idx = {1'b0, rr_q} + 4'(k);
      if (idx >= num_q) idx = idx - num_q;
      if (!found && (4'(k) < num_q) && pend_q[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    pend_d  = pend_q;
    rr_d    = rr_q;
    slot_d  = slot_q;
    ch_d    = ch_q;
    ovr_d   = ovr_q;
    clr_d   = clr_q;
    start   = 1'b0;
    wipe    = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_c) wipe = 1'b1;
        else if (start_c && num_q != 4'd0) begin
          start   = 1'b1;
          pend_d  = cfg;
          rr_d    = '0;
          state_d = ARB;
        end else if (|add_v) num_d = num_q + 4'd1;
      end
      ARB: begin
        if (halt) begin
          pend_d  = '0;
          wipe    = clr_c;
          state_d = IDLE;
        end else begin
          pend_d = pend_run;
          ovr_d  = ovr_q || ovr_hit;
          if (found) begin
            slot_d  = pick;
            ch_d    = chan_v[pick];
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        pend_d = pend_run;
        ovr_d  = ovr_q || ovr_hit;
        if (hs) rr_d = (({1'b0, slot_q} + 4'd1) == num_q) ? 3'd0 : slot_q + 3'd1;
        if (halt) begin
          // A halt landing on the handshake cycle has nothing left to drain.
          if (hs) begin
            pend_d  = '0;
            wipe    = clr_c;
            state_d = IDLE;
          end else begin
            clr_d   = clr_c;
            state_d = DRAIN;
          end
        end else if (hs) state_d = ARB;
      end
      DRAIN: begin
        if (clr_c) clr_d = 1'b1;
        if (hs) begin
          pend_d  = '0;
          wipe    = clr_q || clr_c;
          clr_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (wipe) begin
      num_d = 4'd0;
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      num_q   <= '0;
      pend_q  <= '0;
      rr_q    <= '0;
      slot_q  <= '0;
      ch_q    <= 8'hFF;
      ovr_q   <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      pend_q  <= pend_d;
      rr_q    <= rr_d;
      slot_q  <= slot_d;
      ch_q    <= ch_d;
      ovr_q   <= ovr_d;
      clr_q   <= clr_d;
    end
  end
endmodule

// File: tb/tb_collection_scheduler.sv
// Directed bench for collection_scheduler: bus writes, round-robin grants, drain, clear, reset.
module tb_collection_scheduler;
  logic        clk = 1'b0, rst = 1'b1;
  logic [15:0] addr;
  logic [31:0] data;
  logic        cs, wr, ready;
  logic        req_valid, running, overrun;
  logic [7:0]  req_channel;
  logic [2:0]  req_slot;
  logic [3:0]  num_slots;
  int          n_chk = 0, n_fail = 0;

  localparam logic [7:0] POS = 8'd243;

  collection_scheduler dut (
    .clk(clk), .rst(rst), .addr(addr), .cmd_data_in(data), .cs(cs), .wr(wr),
    .req_ready(ready), .req_valid(req_valid), .req_channel(req_channel),
    .req_slot(req_slot), .running(running), .overrun(overrun), .num_slots(num_slots)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus(input logic [7:0] pos, input logic [7:0] r, input logic [31:0] d,
                     input logic c, input logic w);
    @(negedge clk);
    cs = c; wr = w; addr = {pos, r}; data = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic add(input logic [7:0] ch, input logic [23:0] per);
    bus(POS, 8'd4, {per, ch}, 1'b1, 1'b1);
  endtask

  task automatic cmd(input logic [15:0] c);
    bus(POS, 8'd5, {16'd0, c}, 1'b1, 1'b1);
  endtask

  initial begin
    cs = 0; wr = 0; addr = 0; data = 0; ready = 0;
    cyc(2);
    chk("rst_valid", req_valid, 0);
    chk("rst_channel", req_channel, 255);
    chk("rst_slot", req_slot, 0);
    chk("rst_running", running, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_num", num_slots, 0);
    rst = 1'b0;

    // Writes that must be ignored
    bus(8'd242, 8'd4, {24'd4, 8'd1}, 1'b1, 1'b1);
    chk("wrong_pos", num_slots, 0);
    bus(POS, 8'd4, {24'd4, 8'd1}, 1'b0, 1'b1);
    chk("no_cs", num_slots, 0);
    bus(POS, 8'd4, {24'd4, 8'd1}, 1'b1, 1'b0);
    chk("no_wr", num_slots, 0);

    // START with no slots
    cmd(16'd1);
    cyc(2);
    chk("empty_running", running, 0);
    chk("empty_valid", req_valid, 0);

    // Two slots, period 4, always ready: 3,7,3,7
    add(8'd3, 24'd4);
    add(8'd7, 24'd4);
    chk("num_two", num_slots, 2);
    ready = 1'b1;
    cmd(16'd1);
    chk("lat_t1_valid", req_valid, 0);
    chk("lat_t1_running", running, 1);
    cyc(1);
    for (int j = 0; j < 4; j++) begin
      chk("rr_valid", req_valid, 1);
      chk("rr_channel", req_channel, (j % 2 == 1) ? 7 : 3);
      chk("rr_slot", req_slot, j % 2);
      cyc(1);
      chk("rr_gap", req_valid, 0);
      cyc(1);
    end
    chk("rr_overrun", overrun, 0);
    cmd(16'd2);
    chk("stop_running", running, 0);
    chk("stop_valid", req_valid, 0);

    // STOP during a stalled request drains exactly one handshake
    ready = 1'b0;
    cmd(16'd1);
    cyc(1);
    chk("drain_pre_valid", req_valid, 1);
    chk("drain_pre_channel", req_channel, 3);
    cmd(16'd2);
    chk("drain_valid", req_valid, 1);
    chk("drain_running", running, 0);
    cyc(5);
    chk("drain_hold", req_valid, 1);
    chk("drain_hold_channel", req_channel, 3);
    ready = 1'b1;
    cyc(1);
    chk("drain_done_valid", req_valid, 0);
    chk("drain_done_running", running, 0);
    cyc(3);
    chk("drain_idle_valid", req_valid, 0);
    ready = 1'b0;

    // Single fast slot stalled: overrun
    cmd(16'd5);
    chk("clr_idle_num", num_slots, 0);
    add(8'd9, 24'd2);
    cmd(16'd1);
    cyc(10);
    chk("ovr_valid", req_valid, 1);
    chk("ovr_channel", req_channel, 9);
    chk("ovr_slot", req_slot, 0);
    chk("ovr_flag", overrun, 1);
    chk("ovr_running", running, 1);

    // CLEAR mid-request drains, then wipes configuration and overrun
    cmd(16'd5);
    chk("clr_drain_valid", req_valid, 1);
    chk("clr_drain_ovr", overrun, 1);
    chk("clr_drain_num", num_slots, 1);
    ready = 1'b1;
    cyc(1);
    chk("clr_ovr", overrun, 0);
    chk("clr_num", num_slots, 0);
    chk("clr_valid", req_valid, 0);
    chk("clr_running", running, 0);

    // ADD_SLOT ignored while running; capped at MAX_SLOTS
    add(8'd20, 24'd3);
    add(8'd21, 24'd3);
    add(8'd22, 24'd3);
    chk("num_three", num_slots, 3);
    cmd(16'd1);
    add(8'd30, 24'd3);
    chk("add_running_num", num_slots, 3);
    chk("add_running", running, 1);
    cmd(16'd2);
    chk("stop2_running", running, 0);
    chk("stop2_valid", req_valid, 0);
    for (int i = 0; i < 6; i++) add(8'(40 + i), 24'd3);
    chk("num_max", num_slots, 8);

    // Reset mid-request
    ready = 1'b0;
    cmd(16'd1);
    cyc(1);
    chk("pre_rst_valid", req_valid, 1);
    chk("pre_rst_channel", req_channel, 20);
    rst = 1'b1;
    cyc(1);
    chk("mid_rst_valid", req_valid, 0);
    chk("mid_rst_channel", req_channel, 255);
    chk("mid_rst_num", num_slots, 0);
    chk("mid_rst_running", running, 0);
    rst = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
